trap_arbiter: RTL and testbench

TRAP_ARBITER -- requirements
Module: trap_arbiter

---
 rtl/trap_arbiter_pkg.sv | 20 ++
 rtl/trap_prio_sel.sv | 33 +++
 rtl/trap_arbiter.sv | 137 +++++++++++++
 tb/tb_trap_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_arbiter_pkg.sv
// Shared trap-type constants, source indices and the arbiter state type.
package trap_arbiter_pkg;

  localparam logic [7:0] TT_ASYNC_ERR = 8'h01;
  localparam logic [7:0] TT_NMI       = 8'h30;
  localparam logic [7:0] TT_INT_BASE  = 8'h30;

  localparam int unsigned SRC_ASYNC = 0;
  localparam int unsigned SRC_NMI   = 1;
  localparam int unsigned SRC_SYNC  = 2;
  localparam int unsigned SRC_INT   = 3;
  localparam int unsigned NUM_SRC   = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BLOCK
  } state_e;

endpackage

// File: rtl/trap_prio_sel.sv
// Fixed-priority trap source selector: async error > NMI > sync trap > interrupt.
module trap_prio_sel
  import trap_arbiter_pkg::*;
(
  input  logic               async_pend,
  input  logic               nmi_pend,
  input  logic               sync_vld,
  input  logic [7:0]         sync_tt,
  input  logic               int_vld,
  input  logic [3:0]         irl,
  output logic [7:0]         win_tt,
  output logic [NUM_SRC-1:0] grant
);

  always_comb begin
    win_tt = '0;
    grant  = '0;
    if (async_pend) begin
      win_tt            = TT_ASYNC_ERR;
      grant[SRC_ASYNC]  = 1'b1;
    end else if (nmi_pend) begin
      win_tt            = TT_NMI;
      grant[SRC_NMI]    = 1'b1;
    end else if (sync_vld) begin
      win_tt            = sync_tt;
      grant[SRC_SYNC]   = 1'b1;
    end else if (int_vld) begin
      win_tt            = TT_INT_BASE + {4'h0, irl};
      grant[SRC_INT]    = 1'b1;
    end
  end

endmodule

// File: rtl/trap_arbiter.sv
// Trap arbiter: latches trap sources, offers the highest-priority one to the
// pipeline, strobes TBASE.TT on acceptance and then blocks for HOLD_CYCLES.
module trap_arbiter
  import trap_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        async_err,
  input  logic        nmi,
  input  logic        sync_vld_e,
  input  logic [7:0]  sync_tt_e,
  input  logic [3:0]  irl,
  input  logic        psr_ie,
  input  logic [3:0]  psr_pil,
  input  logic        trap_ack,
  output logic        trap_req,
  output logic        tbase_tt_we_e,
  output logic [7:0]  tbase_tt_e,
  output logic [31:0] trap_count
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES);

  state_e state_q, state_d;
  logic [7:0]  tt_q, tt_d;
  logic        src_async_q, src_async_d;
  logic        src_nmi_q, src_nmi_d;
  logic [3:0]  hold_q, hold_d;
  logic        async_err_q, nmi_q, nmi_prev_q, nmi_armed_q;
  logic [31:0] count_q;

  logic               async_pend, nmi_edge, nmi_pend, int_vld, any_vld, take;
  logic [7:0]         win_tt;
  logic [NUM_SRC-1:0] grant;

  // Pending views include this cycle's input so a same-cycle error can preempt.
  assign async_pend = async_err_q | async_err;
  // nmi_armed_q stays low until nmi is seen low after reset.
  assign nmi_edge   = nmi & ~nmi_prev_q & nmi_armed_q;
  assign nmi_pend   = nmi_q | nmi_edge;
  assign int_vld    = psr_ie && (irl != 4'd0) && (irl > psr_pil);

  trap_prio_sel u_prio_sel (
    .async_pend (async_pend),
    .nmi_pend   (nmi_pend),
    .sync_vld   (sync_vld_e),
    .sync_tt    (sync_tt_e),
    .int_vld    (int_vld),
    .irl        (irl),
    .win_tt     (win_tt),
    .grant      (grant)
  );

  assign any_vld = |grant;

  always_comb begin
    state_d     = state_q;
    tt_d        = tt_q;
    src_async_d = src_async_q;
    src_nmi_d   = src_nmi_q;
    hold_d      = hold_q;
    take        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_vld) begin
          state_d     = REQ;
          tt_d        = win_tt;
          src_async_d = grant[SRC_ASYNC];
          src_nmi_d   = grant[SRC_NMI];
        end
      end
      REQ: begin
        if (async_pend && (tt_q != TT_ASYNC_ERR)) begin
          tt_d        = TT_ASYNC_ERR;
          src_async_d = 1'b1;
          src_nmi_d   = 1'b0;
        end else if (trap_ack) begin
          take    = 1'b1;
          hold_d  = HOLD_LOAD;
          state_d = BLOCK;
        end
      end
      BLOCK: begin
        hold_d = hold_q - 4'd1;
        if (hold_q <= 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tt_q        <= '0;
      src_async_q <= 1'b0;
      src_nmi_q   <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      tt_q        <= tt_d;
      src_async_q <= src_async_d;
      src_nmi_q   <= src_nmi_d;
      hold_q      <= hold_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      async_err_q <= 1'b0;
      nmi_q       <= 1'b0;
      nmi_prev_q  <= 1'b0;
      nmi_armed_q <= 1'b0;
    end else begin
      async_err_q <= (take && src_async_q) ? 1'b0 : async_pend;
      nmi_q       <= (take && src_nmi_q)   ? 1'b0 : nmi_pend;
      nmi_prev_q  <= nmi;
      nmi_armed_q <= nmi_armed_q | ~nmi;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (take && (count_q != '1)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign trap_req      = (state_q == REQ);
  assign tbase_tt_we_e = take;
  assign tbase_tt_e    = tt_q;
  assign trap_count    = count_q;

endmodule

// File: tb/tb_trap_arbiter.sv
// Self-checking bench for trap_arbiter: directed scenarios plus random stimulus
// against a cycle-level behavioural model.
module tb_trap_arbiter;

  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        async_err = 1'b0, nmi = 1'b0, sync_vld_e = 1'b0;
  logic [7:0]  sync_tt_e = '0;
  logic [3:0]  irl = '0, psr_pil = '0;
  logic        psr_ie = 1'b0, trap_ack = 1'b0;
  logic        trap_req, tbase_tt_we_e;
  logic [7:0]  tbase_tt_e;
  logic [31:0] trap_count;

  trap_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .async_err(async_err), .nmi(nmi),
    .sync_vld_e(sync_vld_e), .sync_tt_e(sync_tt_e), .irl(irl),
    .psr_ie(psr_ie), .psr_pil(psr_pil), .trap_ack(trap_ack),
    .trap_req(trap_req), .tbase_tt_we_e(tbase_tt_we_e),
    .tbase_tt_e(tbase_tt_e), .trap_count(trap_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Behavioural model: offering flag, remaining blocked cycles, sticky flags.
  bit              m_aq, m_nq, m_prev, m_armed, m_offering;
  bit              m_src_async, m_src_nmi;
  logic [7:0]      m_tt;
  int              m_hold_left;
  longint unsigned m_count;

  logic        obs_req, obs_we;
  logic [7:0]  obs_tt;
  logic [31:0] obs_count;
  logic [7:0]  strobe_q[$];

  task automatic model_reset();
    m_aq = 0; m_nq = 0; m_prev = 0; m_armed = 0; m_offering = 0;
    m_src_async = 0; m_src_nmi = 0; m_tt = '0; m_hold_left = 0; m_count = 0;
  endtask

  function automatic bit model_preempt();
    return m_offering && (m_aq || async_err) && (m_tt != 8'h01);
  endfunction

  task automatic model_step();
    bit a_pend, edge_seen, n_pend, iv, pre, tk;
    a_pend    = m_aq || async_err;
    edge_seen = nmi && !m_prev && m_armed;
    n_pend    = m_nq || edge_seen;
    iv        = psr_ie && (irl != 0) && (int'(irl) > int'(psr_pil));
    pre       = model_preempt();
    tk        = m_offering && trap_ack && !pre;
    m_aq = (tk && m_src_async) ? 1'b0 : a_pend;
    m_nq = (tk && m_src_nmi) ? 1'b0 : n_pend;
    if (m_hold_left > 0) begin
      m_hold_left--;
    end else if (m_offering) begin
      if (pre) begin
        m_tt = 8'h01; m_src_async = 1; m_src_nmi = 0;
      end else if (tk) begin
        m_offering  = 0;
        m_hold_left = HOLD;
        if (m_count < 64'hFFFF_FFFF) m_count++;
      end
    end else if (a_pend) begin
      m_offering = 1; m_tt = 8'h01; m_src_async = 1; m_src_nmi = 0;
    end else if (n_pend) begin
      m_offering = 1; m_tt = 8'h30; m_src_async = 0; m_src_nmi = 1;
    end else if (sync_vld_e) begin
      m_offering = 1; m_tt = sync_tt_e; m_src_async = 0; m_src_nmi = 0;
    end else if (iv) begin
      m_offering = 1; m_tt = 8'(8'h30 + int'(irl)); m_src_async = 0; m_src_nmi = 0;
    end
    m_prev  = nmi;
    m_armed = m_armed || !nmi;
  endtask

  // One clock: compare at negedge, advance model at posedge, return 1 after it.
  task automatic cyc();
    bit e_we;
    @(negedge clk);
    obs_req = trap_req; obs_we = tbase_tt_we_e; obs_tt = tbase_tt_e; obs_count = trap_count;
    e_we = m_offering && trap_ack && !model_preempt();
    check("trap_req", {31'd0, obs_req}, {31'd0, m_offering});
    check("tt_we", {31'd0, obs_we}, {31'd0, e_we});
    check("tt", {24'd0, obs_tt}, {24'd0, m_tt});
    check("count", obs_count, m_count[31:0]);
    if (obs_we) strobe_q.push_back(obs_tt);
    @(posedge clk);
    if (!reset) model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    cyc();
    reset = 1'b0;
  endtask

  task automatic clear_inputs();
    async_err = 0; nmi = 0; sync_vld_e = 0; sync_tt_e = '0;
    irl = '0; psr_pil = '0; psr_ie = 0; trap_ack = 0;
  endtask

  initial begin
    int gap;
    bit hit;
    model_reset();
    #1;

    // Sync trap B6, ack two cycles after the offer, BLOCK of HOLD cycles.
    do_reset();
    check("rst_count", obs_count, 32'd0);
    sync_vld_e = 1; sync_tt_e = 8'hB6;
    cyc();
    cyc();
    check("s035_latency", {31'd0, obs_req}, 32'd1);
    cyc();
    trap_ack = 1; strobe_q.delete();
    cyc();
    check("s035_we", {31'd0, obs_we}, 32'd1);
    check("s035_tt", {24'd0, obs_tt}, 32'hB6);
    trap_ack = 0; gap = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (obs_req) break;
      gap++;
    end
    check("s035_gap", gap, HOLD + 1);
    check("s035_strobes", strobe_q.size(), 32'd1);
    check("s035_count", obs_count, 32'd1);

    // Async error, NMI edge and interrupt all in one cycle.
    clear_inputs();
    do_reset();
    cyc(); cyc();
    async_err = 1; nmi = 1; irl = 4'd5; psr_pil = 4'd2; psr_ie = 1; trap_ack = 1;
    strobe_q.delete();
    cyc();
    async_err = 0;
    for (int i = 0; i < 40 && strobe_q.size() < 3; i++) cyc();
    check("s036_strobes", strobe_q.size(), 32'd3);
    if (strobe_q.size() == 3) begin
      check("s036_tt0", {24'd0, strobe_q[0]}, 32'h01);
      check("s036_tt1", {24'd0, strobe_q[1]}, 32'h30);
      check("s036_tt2", {24'd0, strobe_q[2]}, 32'h35);
    end
    trap_ack = 0; irl = '0;
    cyc();
    check("s036_count", obs_count, 32'd3);

    // Async error preempts an offered B4 even with ack present.
    clear_inputs();
    do_reset();
    sync_vld_e = 1; sync_tt_e = 8'hB4;
    cyc();
    sync_vld_e = 0;
    cyc();
    check("s037_tt_b4", {24'd0, obs_tt}, 32'hB4);
    async_err = 1; trap_ack = 1;
    cyc();
    check("s037_no_we", {31'd0, obs_we}, 32'd0);
    async_err = 0;
    cyc();
    check("s037_we", {31'd0, obs_we}, 32'd1);
    check("s037_tt01", {24'd0, obs_tt}, 32'h01);
    trap_ack = 0;

    // Interrupt masking boundaries.
    clear_inputs();
    do_reset();
    irl = 4'd3; psr_pil = 4'd3; psr_ie = 1; hit = 0;
    repeat (5) begin cyc(); hit |= obs_req; end
    check("s038_eq_level", {31'd0, hit}, 32'd0);
    irl = 4'd3; psr_pil = 4'd0; psr_ie = 0; hit = 0;
    repeat (5) begin cyc(); hit |= obs_req; end
    check("s038_ie_off", {31'd0, hit}, 32'd0);
    irl = 4'd4; psr_pil = 4'd3; psr_ie = 1;
    cyc(); cyc();
    check("s038_req", {31'd0, obs_req}, 32'd1);
    check("s038_tt", {24'd0, obs_tt}, 32'h34);

    // Reset mid-BLOCK, mid-REQ, and NMI held high through reset.
    clear_inputs();
    do_reset();
    sync_vld_e = 1; sync_tt_e = 8'h42;
    cyc();
    sync_vld_e = 0;
    cyc();
    trap_ack = 1;
    cyc();
    trap_ack = 0;
    reset = 1; model_reset();
    cyc();
    check("s039_blk_req", {31'd0, obs_req}, 32'd0);
    check("s039_blk_count", obs_count, 32'd0);
    reset = 0;
    sync_vld_e = 1;
    cyc(); cyc();
    trap_ack = 1; reset = 1; model_reset();
    cyc();
    check("s039_req_we", {31'd0, obs_we}, 32'd0);
    check("s039_req_count", obs_count, 32'd0);
    reset = 0; trap_ack = 0; sync_vld_e = 0;
    nmi = 1;
    cyc();
    reset = 1; model_reset();
    cyc();
    reset = 0; hit = 0;
    repeat (5) begin cyc(); hit |= obs_req; end
    check("s039_nmi_held", {31'd0, hit}, 32'd0);
    nmi = 0;
    cyc();
    nmi = 1;
    cyc(); cyc();
    check("s039_nmi_req", {31'd0, obs_req}, 32'd1);
    check("s039_nmi_tt", {24'd0, obs_tt}, 32'h30);

    // Saturation of the trap counter.
    clear_inputs();
    do_reset();
    force dut.count_q = 32'hFFFF_FFFF;
    m_count = 64'hFFFF_FFFF;
    cyc();
    release dut.count_q;
    sync_vld_e = 1; sync_tt_e = 8'h11; trap_ack = 1; strobe_q.delete();
    for (int i = 0; i < 10 && strobe_q.size() < 1; i++) cyc();
    check("s040_strobe", strobe_q.size(), 32'd1);
    sync_vld_e = 0; trap_ack = 0;
    cyc();
    check("s040_sat", obs_count, 32'hFFFF_FFFF);

    // Random traffic against the model.
    clear_inputs();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset = 1; model_reset();
      end else begin
        reset = 0;
      end
      async_err  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) nmi = ~nmi;
      sync_vld_e = ($urandom_range(0, 2) == 0);
      sync_tt_e  = 8'($urandom);
      irl        = 4'($urandom);
      psr_pil    = 4'($urandom);
      psr_ie     = 1'($urandom);
      trap_ack   = 1'($urandom);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
